// File: rtl/bp_be_hazard_tracker.sv
// bp_be_hazard_tracker
// ---------------------------------------------------------------------------
// Issue-stage hazard tracker. A shift register of in-flight writers (one
// entry per stage, stage 0 = ex1) supplies RAW and WAW checks against the
// instruction at issue. A per-register-file scoreboard tracks long-latency
// writers once they commit. Structural stalls come from per-pipe busy flags.
//
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   issue_*                   instruction presented at issue (operands, rd, pipe)
//   dispatch_v_i              issue instruction leaves for dispatch this cycle
//   flush_i                   invalidate all in-flight stage entries
//   score_* / clear_*         set / clear one scoreboard bit
//   pipe_busy_i               per-pipe structural busy
//   hazard_v_o                OR of data/waw/struct stalls
//   data_haz_o, waw_haz_o,
//   struct_haz_o              individual stall causes (gated by issue_v_i)
//   sb_empty_o                no scoreboard bit set (registered state)
//   stall_cnt_o               {struct, waw, data} 32-bit stall-cycle counters
//
// Optional feature: define BP_BE_HAZARD_TRACKER_STATS_EN to build saturating
// stall counters; otherwise stall_cnt_o is tied to zero.
// ---------------------------------------------------------------------------
module bp_be_hazard_tracker #(
    parameter int num_stages_p     = 4,
    parameter int num_rs_p         = 3,
    parameter int num_rf_p         = 2,
    parameter int reg_addr_width_p = 5,
    parameter int num_pipes_p      = 8,
    parameter logic [num_pipes_p*3-1:0] pipe_lat_p = {num_pipes_p{3'd1}},
    localparam int rf_id_w   = (num_rf_p > 1) ? $clog2(num_rf_p) : 1,
    localparam int pipe_id_w = (num_pipes_p > 1) ? $clog2(num_pipes_p) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 issue_v_i,
    input  logic [num_rs_p-1:0]                  issue_rs_v_i,
    input  logic [num_rs_p*rf_id_w-1:0]          issue_rs_rf_i,
    input  logic [num_rs_p*reg_addr_width_p-1:0] issue_rs_addr_i,
    input  logic                                 issue_rd_v_i,
    input  logic [rf_id_w-1:0]                   issue_rd_rf_i,
    input  logic [reg_addr_width_p-1:0]          issue_rd_addr_i,
    input  logic [pipe_id_w-1:0]                 issue_pipe_i,
    input  logic                                 dispatch_v_i,
    input  logic                                 flush_i,
    input  logic                                 score_v_i,
    input  logic [rf_id_w-1:0]                   score_rf_i,
    input  logic [reg_addr_width_p-1:0]          score_addr_i,
    input  logic                                 clear_v_i,
    input  logic [rf_id_w-1:0]                   clear_rf_i,
    input  logic [reg_addr_width_p-1:0]          clear_addr_i,
    input  logic [num_pipes_p-1:0]               pipe_busy_i,
    output logic                                 hazard_v_o,
    output logic                                 data_haz_o,
    output logic                                 waw_haz_o,
    output logic                                 struct_haz_o,
    output logic                                 sb_empty_o,
    output logic [3*32-1:0]                      stall_cnt_o
);

    // Scoreboard is indexed by {rf, addr}; sized to the full index space so
    // the concatenation can be used directly.
    localparam int sb_w = 1 << (rf_id_w + reg_addr_width_p);

    typedef struct packed {
        logic                        v;
        logic                        rd_v;
        logic [rf_id_w-1:0]          rd_rf;
        logic [reg_addr_width_p-1:0] rd_addr;
        logic [2:0]                  lat;
    } entry_t;

    entry_t                      stage_reg [num_stages_p];
    logic [sb_w-1:0]             sb_reg;
    logic [2:0]                  issue_lat;
    logic                        load;
    logic                        raw_hit;
    logic                        waw_hit;
    logic [rf_id_w-1:0]          rs_rf;
    logic [reg_addr_width_p-1:0] rs_addr;
    logic                        rd_is_x0;

    genvar gi;

    // Out-of-range pipe indices read back latency 0 via the shift.
    assign issue_lat = 3'(pipe_lat_p >> (3 * issue_pipe_i));
    assign load      = dispatch_v_i & issue_v_i & ~hazard_v_o & ~flush_i;

    // In-flight stage shift register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < num_stages_p; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0].v       <= load;
            stage_reg[0].rd_v    <= issue_rd_v_i;
            stage_reg[0].rd_rf   <= issue_rd_rf_i;
            stage_reg[0].rd_addr <= issue_rd_addr_i;
            stage_reg[0].lat     <= issue_lat;
            for (int i = 1; i < num_stages_p; i++) begin
                stage_reg[i]   <= stage_reg[i-1];
                stage_reg[i].v <= stage_reg[i-1].v & ~flush_i;
            end
        end
    end

    // Scoreboard: the score write comes last so it wins on a same-target
    // collision with clear. Integer x0 is never scored.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sb_reg <= '0;
        end else begin
            if (clear_v_i) begin
                sb_reg[{clear_rf_i, clear_addr_i}] <= 1'b0;
            end
            if (score_v_i && !(score_rf_i == '0 && score_addr_i == '0)) begin
                sb_reg[{score_rf_i, score_addr_i}] <= 1'b1;
            end
        end
    end

    assign rd_is_x0 = (issue_rd_rf_i == '0) && (issue_rd_addr_i == '0);

    always_comb begin
        raw_hit = 1'b0;
        waw_hit = 1'b0;
        rs_rf   = '0;
        rs_addr = '0;
        for (int j = 0; j < num_rs_p; j++) begin
            rs_rf   = issue_rs_rf_i[j*rf_id_w +: rf_id_w];
            rs_addr = issue_rs_addr_i[j*reg_addr_width_p +: reg_addr_width_p];
            if (issue_rs_v_i[j] && !(rs_rf == '0 && rs_addr == '0)) begin
                if (sb_reg[{rs_rf, rs_addr}]) begin
                    raw_hit = 1'b1;
                end
                // Short writer still inside its forwarding window.
                for (int i = 0; i < num_stages_p; i++) begin
                    if (stage_reg[i].v && stage_reg[i].rd_v
                        && stage_reg[i].rd_rf == rs_rf && stage_reg[i].rd_addr == rs_addr
                        && stage_reg[i].lat != 3'd0
                        && {29'b0, stage_reg[i].lat} > 32'(i + 1)) begin
                        raw_hit = 1'b1;
                    end
                end
            end
        end
        if (issue_rd_v_i && !rd_is_x0) begin
            if (sb_reg[{issue_rd_rf_i, issue_rd_addr_i}]) begin
                waw_hit = 1'b1;
            end
            // Long writer in flight but not yet on the scoreboard.
            for (int i = 0; i < num_stages_p; i++) begin
                if (stage_reg[i].v && stage_reg[i].rd_v
                    && stage_reg[i].rd_rf == issue_rd_rf_i
                    && stage_reg[i].rd_addr == issue_rd_addr_i
                    && stage_reg[i].lat == 3'd0) begin
                    waw_hit = 1'b1;
                end
            end
        end
    end

    assign data_haz_o   = issue_v_i & raw_hit;
    assign waw_haz_o    = issue_v_i & waw_hit;
    assign struct_haz_o = issue_v_i & |(pipe_busy_i & ({{(num_pipes_p-1){1'b0}}, 1'b1} << issue_pipe_i));
    assign hazard_v_o   = data_haz_o | waw_haz_o | struct_haz_o;
    assign sb_empty_o   = ~|sb_reg;

`ifdef BP_BE_HAZARD_TRACKER_STATS_EN
    logic [31:0] cnt_reg [3];
    logic [2:0]  cnt_inc;

    assign cnt_inc = {struct_haz_o, waw_haz_o, data_haz_o};

    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && cnt_reg[gi] != 32'hFFFF_FFFF) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign stall_cnt_o = {cnt_reg[2], cnt_reg[1], cnt_reg[0]};
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/bp_be_hazard_tracker.md
Name: bp_be_hazard_tracker

Overview:
- Parametrised issue-stage hazard tracker for the BE checker.
- Tracks in-flight writers across N pipe stages with per-pipe result latencies.
- Keeps a scoreboard per register file for long-latency writers, and raises data, WAW and structural stalls for the instruction at issue.
- Generalises the fixed-depth, fixed-pipe detector to any stage depth, operand count, register-file count and pipe latency table.
- Sits between issue queue and dispatch; feeds hazard_v_o to the director/dispatch stall logic.

Parameters:
- num_stages_p, 4, in-flight status depth (stage 0 = ex1); must be ≥ max pipe latency.
- num_rs_p, 3, source operands checked per instruction.
- num_rf_p, 2, register files (rf 0 = integer, x0 hardwired).
- reg_addr_width_p, 5, register address width.
- num_pipes_p, 8, execution pipes.
- pipe_lat_p, {8{3'd1}}, packed num_pipes_p×3-bit table. lat ≥ 1 = cycles until forwardable; 0 = long-latency (scoreboarded).
- Derived: rf_id_w = `BSG_SAFE_CLOG2(num_rf_p)`, pipe_id_w = `BSG_SAFE_CLOG2(num_pipes_p)`.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- issue_v_i  in  1  instruction valid at issue
- issue_rs_v_i  in  num_rs_p  per-operand read enable
- issue_rs_rf_i  in  num_rs_p*rf_id_w  per-operand register file
- issue_rs_addr_i  in  num_rs_p*reg_addr_width_p  per-operand address
- issue_rd_v_i  in  1  writes a destination
- issue_rd_rf_i  in  rf_id_w  destination register file
- issue_rd_addr_i  in  reg_addr_width_p  destination address
- issue_pipe_i  in  pipe_id_w  target pipe index
- dispatch_v_i  in  1  issue instruction dispatched this cycle
- flush_i  in  1  kill all in-flight status entries
- score_v_i  in  1  long-latency writer commits; set scoreboard bit
- score_rf_i / score_addr_i  in  rf_id_w / reg_addr_width_p  scoreboard set target
- clear_v_i  in  1  late writeback accepted; clear scoreboard bit
- clear_rf_i / clear_addr_i  in  rf_id_w / reg_addr_width_p  scoreboard clear target
- pipe_busy_i  in  num_pipes_p  per-pipe structural busy
- hazard_v_o  out  1  stall issue (OR of causes below)
- data_haz_o  out  1  RAW stall
- waw_haz_o  out  1  WAW stall
- struct_haz_o  out  1  structural stall
- sb_empty_o  out  1  no scoreboard bits set (ordering/fence use)
- stall_cnt_o  out  3*32  {struct,waw,data} stall-cycle counters (optional feature)

Behaviour:
- **Reset.** Async reset clears all stage entries and all scoreboard bits. At reset: hazard_v_o=0, data_haz_o=0, waw_haz_o=0, struct_haz_o=0, sb_empty_o=1, stall_cnt_o=0.
- **Stage entry.** Each entry holds {v, rd_v, rd_rf, rd_addr, lat}.
- **Stage 0 load.** At every posedge, stage 0 loads the issue fields when dispatch_v_i & issue_v_i & ~hazard_v_o & ~flush_i. Otherwise stage 0 loads an invalid entry. lat = pipe_lat_p[issue_pipe_i].
- **Shift.** Stage i+1 ← stage i every cycle. The last stage drops.
- **Flush.** flush_i clears the v bit of all stages next cycle and blocks the same-cycle load. The scoreboard is unaffected.
- **Operand match.** Operand j matches stage i iff rs_v[j] & stage[i].v & stage[i].rd_v & rf equal & addr equal & ~(rf==0 & addr==0).
- **RAW from stages.** data_haz_o includes any operand matching stage i with lat ≠ 0 and i+1 < lat.
- **RAW from scoreboard.** data_haz_o also includes any operand whose scoreboard bit is set.
- **WAW from stages.** Applies only if issue_rd_v_i and the rd is not int x0. waw_haz_o when rd matches stage i with lat == 0 (long writer not yet scored).
- **WAW from scoreboard.** waw_haz_o also when rd's scoreboard bit is set.
- **Structural.** struct_haz_o = issue_v_i & pipe_busy_i[issue_pipe_i].
- **Gating.** All hazard outputs are combinational and gated by issue_v_i. hazard_v_o = data_haz_o | waw_haz_o | struct_haz_o.
- **Scoreboard.** One bit per (rf, reg); int x0 is never set.
  - Same cycle, same target for score and clear: the bit ends set (score wins).
  - Different targets: both are applied.
  - Score of an already-set bit keeps it set; clear of a clear bit is a no-op.
  - Updates become visible to hazard checks the next cycle.
- **sb_empty_o** = ~|scoreboard, registered state only.

Optional Feature:
- Macro: `BP_BE_HAZARD_TRACKER_STATS_EN`.
- **Defined:** three 32-bit counters increment each cycle that data_haz_o, waw_haz_o or struct_haz_o is high, respectively.
  - Counters saturate at 0xFFFFFFFF.
  - Async reset clears them to 0.
  - stall_cnt_o = {struct, waw, data}.
- **Undefined:** no counters are built; stall_cnt_o is tied to 0.

Test Plan:
- **Forwarding window.** Pipe 2 has lat=3. Dispatch a writer of int x5 via pipe 2, then issue a reader of x5 on each of the next 3 cycles -> data_haz_o=1 at the first two checks (writer in stages 0,1), 0 at the third (stage 2).
- **x0 and rf separation.** Writer of int x0 with lat=3 followed by a reader of x0 -> no hazard. A reader of fp f5 after an int x5 writer -> no hazard.
- **Scoreboard set/clear.** Long writer to fp f7, then score_v_i(rf1, 7). A reader of f7 stalls until the cycle after clear_v_i(rf1, 7); simultaneous score+clear of f7 leaves it stalled and sb_empty_o=0.
- **WAW.** Long writer to x9 sits in stage 1 unscored; an issue writing x9 -> waw_haz_o=1, data_haz_o=0.
- **Flush and gating.** Dispatch a lat=3 writer of x4, assert flush_i next cycle; a reader of x4 one cycle later -> no hazard. Also assert dispatch_v_i while hazard_v_o=1 -> stage 0 stays invalid.
- **Structural, stats, reset.** pipe_busy_i[3]=1 with issue_pipe_i=3 for 10 cycles -> struct_haz_o=1 and, with STATS_EN, struct counter = 10. Assert async reset mid-run -> all outputs at reset values, sb_empty_o=1.
